exmem_memwb_pipe: RTL and testbench
===================================

# exmem_memwb_pipe

Pipeline register pair between Execute and Writeback: the EX/MEM and MEM/WB stages of the 5-stage pipeline. Captures the EX result each cycle, drives data-memory control from MEM, selects writeback data in WB, and publishes the two destination/write-enable pairs consumed by the forwarding unit. It also implements memory-stall freeze, EX-flush bubble insertion and a retired-instruction counter.

## Interface
- No parameters; data width fixed at 32, register index at 5.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- mem_stall  in  1  data memory not ready; freeze both stages
- flush_ex  in  1  discard the EX entry presented this cycle (insert bubble)
- ex_valid  in  1  EX holds a real instruction
- ex_regwr, ex_memtoreg, ex_memwr, ex_memrd  in  1 each  EX control bits
- ex_rd  in  5  destination register
- ex_alu_out  in  32  ALU result / memory address
- ex_store_data  in  32  forwarded Rt value for stores
- dmem_rdata  in  32  data memory read data (valid in MEM when ~mem_stall)
- mem_regwr  out  1  RegWr of MEM entry (forwarding source 1)
- mem_rd  out  5  Rd of MEM entry (forwarding source 1)
- mem_alu_out  out  32  MEM address / ALU result (forwarded value 1)
- mem_store_data  out  32  data memory write data
- mem_memwr, mem_memrd  out  1 each  data memory strobes
- wb_regwr  out  1  register file write enable (forwarding source 2)
- wb_rd  out  5  register file write index (forwarding source 2)
- wb_data  out  32  register file write data (forwarded value 2)
- retired  out  32  count of instructions leaving WB

## Operation
- Internal state: EX/MEM {valid, regwr, memtoreg, memwr, memrd, rd, alu_out, store_data}; MEM/WB {valid, regwr, memtoreg, rd, alu_out, rdata}; retired counter.
- Normal cycle (~mem_stall): EX/MEM <= EX inputs; MEM/WB <= EX/MEM contents plus dmem_rdata.
- flush_ex & ~mem_stall: EX/MEM.valid <= 0; all its control bits <= 0; data fields don't-care (implementation clears them to 0).
- mem_stall: both stages hold every field; flush_ex ignored (EX upstream is also frozen and re-presents the same entry).
- Output gating: mem_regwr = valid & regwr; mem_memwr/mem_memrd = valid & bit; wb_regwr = valid & regwr & (rd != 0). mem_rd/wb_rd pass raw; the forwarding unit applies its own Rd != 0 check.
- wb_data = memtoreg ? rdata : alu_out (combinational from MEM/WB).
- retired increments by 1 on each rising edge where MEM/WB.valid & ~mem_stall; wraps 0xFFFFFFFF -> 0.
- Priority: rst > mem_stall > flush_ex > normal capture.

## Timing
- Latency: EX input at edge N appears on mem_* after edge N, on wb_* after edge N+1.
- Reset: every state bit 0; all outputs 0 (mem_regwr, mem_rd, mem_alu_out, mem_store_data, mem_memwr, mem_memrd, wb_regwr, wb_rd, wb_data, retired).
- rst asserted mid-stall or mid-flush: state cleared on that edge; stall/flush have no effect that cycle.
- During a stall, wb_regwr stays asserted on the held entry; the repeated register-file write is idempotent and is required so WB forwarding remains valid for the frozen EX instruction. retired counts that entry once, on the edge that releases the stall.
- No combinational path from any input to any output except dmem_rdata -> none (rdata is registered) and MEM/WB fields -> wb_data.

## Structure
- Shared package: control-bundle typedef {regwr, memtoreg, memwr, memrd}, widths DATA_W=32, REG_W=5.
- One natural sub-module: pipe_stage_reg (enable = ~stall, clear = rst | flush), instantiated twice with different field sets.

## Test plan
- Reset: assert rst 2 cycles with nonzero inputs -> every output 0, retired 0.
- ALU op: ex_valid=1, regwr=1, rd=5, alu_out=0x1234 -> next cycle mem_regwr=1, mem_rd=5; following cycle wb_regwr=1, wb_rd=5, wb_data=0x1234, retired=1 after next edge.
- Load: memtoreg=1, memrd=1, rd=8, dmem_rdata=0xDEADBEEF during MEM -> wb_data=0xDEADBEEF, mem_memrd=1 for exactly one cycle.
- Flush: flush_ex=1 with regwr=1, memwr=1, rd=9 -> mem_regwr=0, mem_memwr=0, then wb_regwr=0, retired unchanged.
- Stall: load in MEM, mem_stall=1 for 3 cycles with flush_ex toggling -> mem_*/wb_* frozen, retired frozen; on release, single advance and retired +1.
- rd=0: regwr=1, rd=0 -> mem_regwr=1, mem_rd=0, wb_regwr=0; retired still +1.

Source files
------------

// File: rtl/exmem_memwb_pipe_pkg.sv
// exmem_memwb_pipe_pkg: shared widths and stage-register layouts for the EX/MEM and MEM/WB pipeline
package exmem_memwb_pipe_pkg;
    localparam int DATA_W = 32;
    localparam int REG_W = 5;
    typedef struct packed {
        logic regwr;
        logic memtoreg;
        logic memwr;
        logic memrd;
    } ctrl_t;
    typedef struct packed {
        logic              valid;
        ctrl_t             ctrl;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] store_data;
    } exmem_t;
    typedef struct packed {
        logic              valid;
        logic              regwr;
        logic              memtoreg;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] rdata;
    } memwb_t;
endpackage

// File: rtl/exmem_memwb_pipe_pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline register with synchronous clear taking priority over enable
module pipe_stage_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // clear wins; otherwise capture only when enabled, else hold
    always_ff @(posedge clk)
        if (clr) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/exmem_memwb_pipe.sv
// exmem_memwb_pipe: EX/MEM and MEM/WB registers with stall freeze, EX flush, WB mux and retire count
module exmem_memwb_pipe
    import exmem_memwb_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_stall,
    input  logic              flush_ex,
    input  logic              ex_valid,
    input  logic              ex_regwr,
    input  logic              ex_memtoreg,
    input  logic              ex_memwr,
    input  logic              ex_memrd,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_regwr,
    output logic [REG_W-1:0]  mem_rd,
    output logic [DATA_W-1:0] mem_alu_out,
    output logic [DATA_W-1:0] mem_store_data,
    output logic              mem_memwr,
    output logic              mem_memrd,
    output logic              wb_regwr,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] retired
);
    exmem_t ex_in, exmem;
    memwb_t mem_in, memwb;

    // pack the EX inputs and the MEM stage contents into next-stage layouts
    always_comb begin
        ex_in.valid         = ex_valid;
        ex_in.ctrl.regwr    = ex_regwr;
        ex_in.ctrl.memtoreg = ex_memtoreg;
        ex_in.ctrl.memwr    = ex_memwr;
        ex_in.ctrl.memrd    = ex_memrd;
        ex_in.rd            = ex_rd;
        ex_in.alu_out       = ex_alu_out;
        ex_in.store_data    = ex_store_data;
        mem_in.valid        = exmem.valid;
        mem_in.regwr        = exmem.ctrl.regwr;
        mem_in.memtoreg     = exmem.ctrl.memtoreg;
        mem_in.rd           = exmem.rd;
        mem_in.alu_out      = exmem.alu_out;
        mem_in.rdata        = dmem_rdata;
    end

    // a flush only turns into a bubble when the pipe is actually advancing
    pipe_stage_reg #(.W($bits(exmem_t))) u_exmem (
        .clk (clk),
        .clr (rst | (flush_ex & ~mem_stall)),
        .en  (~mem_stall),
        .d   (ex_in),
        .q   (exmem)
    );

    pipe_stage_reg #(.W($bits(memwb_t))) u_memwb (
        .clk (clk),
        .clr (rst),
        .en  (~mem_stall),
        .d   (mem_in),
        .q   (memwb)
    );

    // an instruction retires on the edge it leaves WB, so a stalled entry counts once
    always_ff @(posedge clk)
        if (rst) retired <= '0;
        else if (memwb.valid & ~mem_stall) retired <= retired + 1'b1;

    assign mem_regwr      = exmem.valid & exmem.ctrl.regwr;
    assign mem_memwr      = exmem.valid & exmem.ctrl.memwr;
    assign mem_memrd      = exmem.valid & exmem.ctrl.memrd;
    assign mem_rd         = exmem.rd;
    assign mem_alu_out    = exmem.alu_out;
    assign mem_store_data = exmem.store_data;
    assign wb_regwr       = memwb.valid & memwb.regwr & (memwb.rd != '0);
    assign wb_rd          = memwb.rd;
    assign wb_data        = memwb.memtoreg ? memwb.rdata : memwb.alu_out;
endmodule

// File: tb/tb_exmem_memwb_pipe.sv
// tb_exmem_memwb_pipe: directed checks of capture, load, flush, stall, rd=0 and reset behaviour
module tb_exmem_memwb_pipe;
    logic        clk = 0;
    logic        rst, mem_stall, flush_ex;
    logic        ex_valid, ex_regwr, ex_memtoreg, ex_memwr, ex_memrd;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu_out, ex_store_data, dmem_rdata;
    logic        mem_regwr, mem_memwr, mem_memrd, wb_regwr;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_alu_out, mem_store_data, wb_data, retired;
    int          n_checks = 0;
    int          n_fail = 0;

    exmem_memwb_pipe dut (
        .clk(clk), .rst(rst), .mem_stall(mem_stall), .flush_ex(flush_ex),
        .ex_valid(ex_valid), .ex_regwr(ex_regwr), .ex_memtoreg(ex_memtoreg),
        .ex_memwr(ex_memwr), .ex_memrd(ex_memrd), .ex_rd(ex_rd),
        .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .dmem_rdata(dmem_rdata),
        .mem_regwr(mem_regwr), .mem_rd(mem_rd), .mem_alu_out(mem_alu_out),
        .mem_store_data(mem_store_data), .mem_memwr(mem_memwr), .mem_memrd(mem_memrd),
        .wb_regwr(wb_regwr), .wb_rd(wb_rd), .wb_data(wb_data), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, r, m2r, mw, mr, input logic [4:0] rd,
                          input logic [31:0] alu, sd);
        ex_valid = v; ex_regwr = r; ex_memtoreg = m2r; ex_memwr = mw; ex_memrd = mr;
        ex_rd = rd; ex_alu_out = alu; ex_store_data = sd;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_regwr"}, 32'(mem_regwr), 0);
        check({tag, "_mem_rd"}, 32'(mem_rd), 0);
        check({tag, "_mem_alu_out"}, mem_alu_out, 0);
        check({tag, "_mem_store_data"}, mem_store_data, 0);
        check({tag, "_mem_memwr"}, 32'(mem_memwr), 0);
        check({tag, "_mem_memrd"}, 32'(mem_memrd), 0);
        check({tag, "_wb_regwr"}, 32'(wb_regwr), 0);
        check({tag, "_wb_rd"}, 32'(wb_rd), 0);
        check({tag, "_wb_data"}, wb_data, 0);
        check({tag, "_retired"}, retired, 0);
    endtask

    initial begin
        rst = 1; mem_stall = 0; flush_ex = 0; dmem_rdata = 32'hAAAA_5555;
        set_ex(1, 1, 1, 1, 1, 7, 32'hFFFF, 32'h1111);
        tick(); tick();
        check_all_zero("reset");

        rst = 0; dmem_rdata = 0;
        set_ex(1, 1, 0, 0, 0, 5, 32'h1234, 0);
        tick();
        check("alu_mem_regwr", 32'(mem_regwr), 1);
        check("alu_mem_rd", 32'(mem_rd), 5);
        check("alu_mem_alu_out", mem_alu_out, 32'h1234);
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("alu_wb_regwr", 32'(wb_regwr), 1);
        check("alu_wb_rd", 32'(wb_rd), 5);
        check("alu_wb_data", wb_data, 32'h1234);
        check("alu_retired_before", retired, 0);
        check("alu_mem_regwr_bubble", 32'(mem_regwr), 0);
        tick();
        check("alu_retired_after", retired, 1);
        check("alu_wb_regwr_gone", 32'(wb_regwr), 0);

        set_ex(1, 1, 1, 0, 1, 8, 32'h100, 0);
        tick();
        check("ld_mem_memrd", 32'(mem_memrd), 1);
        check("ld_mem_alu_out", mem_alu_out, 32'h100);
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        dmem_rdata = 32'hDEADBEEF;
        tick();
        dmem_rdata = 0;
        check("ld_wb_data", wb_data, 32'hDEADBEEF);
        check("ld_wb_regwr", 32'(wb_regwr), 1);
        check("ld_wb_rd", 32'(wb_rd), 8);
        check("ld_mem_memrd_once", 32'(mem_memrd), 0);
        tick();
        check("ld_retired", retired, 2);

        set_ex(1, 1, 0, 1, 0, 9, 32'h55, 32'h77);
        flush_ex = 1;
        tick();
        flush_ex = 0;
        check("fl_mem_regwr", 32'(mem_regwr), 0);
        check("fl_mem_memwr", 32'(mem_memwr), 0);
        check("fl_mem_store_data", mem_store_data, 0);
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("fl_wb_regwr", 32'(wb_regwr), 0);
        tick();
        check("fl_retired", retired, 2);

        set_ex(1, 1, 0, 0, 0, 3, 32'h33, 0);
        tick();
        set_ex(1, 1, 1, 0, 1, 10, 32'h200, 0);
        tick();
        check("st_pre_retired", retired, 2);
        set_ex(1, 1, 0, 0, 0, 11, 32'h300, 0);
        mem_stall = 1; dmem_rdata = 32'h0BAD;
        for (int i = 0; i < 3; i++) begin
            flush_ex = i[0] ? 1'b0 : 1'b1;
            tick();
            check("st_mem_memrd", 32'(mem_memrd), 1);
            check("st_mem_rd", 32'(mem_rd), 10);
            check("st_mem_alu_out", mem_alu_out, 32'h200);
            check("st_wb_regwr", 32'(wb_regwr), 1);
            check("st_wb_rd", 32'(wb_rd), 3);
            check("st_wb_data", wb_data, 32'h33);
            check("st_retired", retired, 2);
        end
        mem_stall = 0; flush_ex = 0; dmem_rdata = 32'hCAFEF00D;
        tick();
        dmem_rdata = 0;
        check("rel_wb_rd", 32'(wb_rd), 10);
        check("rel_wb_data", wb_data, 32'hCAFEF00D);
        check("rel_retired", retired, 3);
        check("rel_mem_rd", 32'(mem_rd), 11);
        check("rel_mem_alu_out", mem_alu_out, 32'h300);
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("rel2_retired", retired, 4);
        check("rel2_wb_data", wb_data, 32'h300);
        tick();
        check("rel3_retired", retired, 5);

        set_ex(1, 1, 0, 0, 0, 0, 32'h99, 0);
        tick();
        check("r0_mem_regwr", 32'(mem_regwr), 1);
        check("r0_mem_rd", 32'(mem_rd), 0);
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("r0_wb_regwr", 32'(wb_regwr), 0);
        check("r0_wb_data", wb_data, 32'h99);
        tick();
        check("r0_retired", retired, 6);

        set_ex(1, 1, 0, 0, 0, 4, 32'h44, 0);
        tick();
        tick();
        mem_stall = 1; flush_ex = 1; rst = 1;
        tick();
        rst = 0; mem_stall = 0; flush_ex = 0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        check_all_zero("rst_stall");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
